// File: rtl/dpa_scheduler.sv
// Wavefront 4x4 allocator with per-row packet locks and a rotating
// diagonal priority origin.
module dpa_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic [3:0]  tail,
  output logic [15:0] grant,
  output logic        grant_valid,
  output logic [3:0]  ptr
);

  logic [15:0] grant_q, grant_d;
  logic [15:0] retain_d, new_d;
  logic        valid_q, valid_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  row_busy, col_busy;
  logic [1:0]  r_idx, c_idx;

  always_comb begin
    retain_d = '0;
    new_d    = '0;
    row_busy = '0;
    col_busy = '0;
    r_idx    = '0;
    c_idx    = '0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (grant_q[4*i+j] && req[4*i+j] && !tail[i]) begin
          retain_d[4*i+j] = 1'b1;
          row_busy[i]     = 1'b1;
          col_busy[j]     = 1'b1;
        end
      end
    end

    // Loops run in rotated coordinates; wave d holds cells with r'+c' == d.
    if (en) begin
      for (int d = 0; d < 7; d++) begin
        for (int rp = 0; rp < 4; rp++) begin
          if ((d - rp) >= 0 && (d - rp) <= 3) begin
            r_idx = 2'(rp) + ptr_q[3:2];
            c_idx = 2'(d - rp) + ptr_q[1:0];
            if (req[{r_idx, c_idx}] && !row_busy[r_idx] && !col_busy[c_idx]) begin
              new_d[{r_idx, c_idx}] = 1'b1;
              row_busy[r_idx]       = 1'b1;
              col_busy[c_idx]       = 1'b1;
            end
          end
        end
      end
    end

    grant_d = retain_d | new_d;
    valid_d = |grant_d;
    ptr_d   = (|new_d) ? ptr_q + 4'd1 : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_dpa_scheduler.sv
// Directed bench for dpa_scheduler: rotation, locks, tail release,
// enable gating, reset and pointer wrap, plus a per-cycle matching check.
module tb_dpa_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = '0;
  logic [3:0]  tail = '0;
  logic [15:0] grant;
  logic        grant_valid;
  logic [3:0]  ptr;

  int total = 0;
  int bad = 0;

  dpa_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .tail(tail),
    .grant(grant), .grant_valid(grant_valid), .ptr(ptr)
  );

  always #5 clk = ~clk;

  // One grant per row and column at most, and grant_valid tracks grant.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if ($countones(grant[4*i +: 4]) > 1) begin
          bad++;
          $display("FAIL row_inv row=%0d grant=%h", i, grant);
        end
        total++;
        if ($countones({grant[12+i], grant[8+i], grant[4+i], grant[i]}) > 1) begin
          bad++;
          $display("FAIL col_inv col=%0d grant=%h", i, grant);
        end
      end
      total++;
      if (grant_valid !== (grant != 16'h0)) begin
        bad++;
        $display("FAIL valid_inv grant_valid=%b grant=%h", grant_valid, grant);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic [15:0] g, input logic [3:0] p);
    total++;
    if (grant !== g) begin
      bad++;
      $display("FAIL %s grant got=%h exp=%h", name, grant, g);
    end
    total++;
    if (ptr !== p) begin
      bad++;
      $display("FAIL %s ptr got=%0d exp=%0d", name, ptr, p);
    end
    total++;
    if (grant_valid !== (g != 16'h0)) begin
      bad++;
      $display("FAIL %s grant_valid got=%b exp=%b", name, grant_valid, (g != 16'h0));
    end
  endtask

  task automatic test_reset();
    en = 1'b1; req = 16'hFFFF; tail = 4'h0;
    do_reset();
    expect_state("reset", 16'h0000, 4'd0);
  endtask

  task automatic test_full_load();
    en = 1'b1; tail = 4'hF; req = 16'hFFFF;
    step(); expect_state("full_1", 16'h8421, 4'd1);
    step(); expect_state("full_2", 16'h1842, 4'd2);
    step(); expect_state("full_3", 16'h2184, 4'd3);
  endtask

  task automatic test_lock_hold();
    en = 1'b1; tail = 4'h0; req = 16'h0001;
    do_reset();
    step(); expect_state("lock_first", 16'h0001, 4'd1);
    req = 16'h0013;
    step(); expect_state("lock_hold1", 16'h0001, 4'd1);
    step(); expect_state("lock_hold2", 16'h0001, 4'd1);
    tail = 4'h1;
    step(); expect_state("tail_realloc", 16'h0012, 4'd2);
  endtask

  task automatic test_req_drop();
    en = 1'b1; tail = 4'h0; req = 16'h0001;
    do_reset();
    step(); expect_state("drop_setup", 16'h0001, 4'd1);
    req = 16'h0000;
    step(); expect_state("drop", 16'h0000, 4'd1);
  endtask

  task automatic test_enable_off();
    en = 1'b0; tail = 4'h0; req = 16'hFFFF;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(); expect_state("en_off", 16'h0000, 4'd0);
    end
    en = 1'b1; req = 16'h0001;
    step(); expect_state("en_lock", 16'h0001, 4'd1);
    en = 1'b0; req = 16'h0011;
    step(); expect_state("en_off_hold", 16'h0001, 4'd1);
    tail = 4'h1;
    step(); expect_state("en_off_release", 16'h0000, 4'd1);
  endtask

  task automatic test_back_to_back();
    en = 1'b1; tail = 4'h0; req = 16'h2200;
    do_reset();
    step(); expect_state("b2b_first", 16'h0200, 4'd1);
    tail = 4'h4;
    step(); expect_state("b2b_same_req", 16'h0200, 4'd2);
    tail = 4'h0; req = 16'h2000;
    step(); expect_state("b2b_other_req", 16'h2000, 4'd3);
  endtask

  task automatic test_reset_mid_and_wrap();
    logic [15:0] exp_g;
    logic [3:0]  p;
    logic [1:0]  r, c;
    en = 1'b1; tail = 4'h0; req = 16'hFFFF;
    do_reset();
    step(); expect_state("mid_lock", 16'h8421, 4'd1);
    step(); expect_state("mid_hold", 16'h8421, 4'd1);
    rst = 1'b1;
    step(); expect_state("mid_reset", 16'h0000, 4'd0);
    rst = 1'b0; tail = 4'hF;
    p = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      exp_g = '0;
      for (int t = 0; t < 4; t++) begin
        r = p[3:2] + 2'(t);
        c = p[1:0] + 2'(t);
        exp_g[{r, c}] = 1'b1;
      end
      p = p + 4'd1;
      step(); expect_state("wrap", exp_g, 4'(k));
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_lock_hold();
    test_req_drop();
    test_enable_off();
    test_back_to_back();
    test_reset_mid_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpa_scheduler.md
DPA_SCHEDULER -- requirements
Module: dpa_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `en`: input, 1 bit, allocation enable.
REQ-005 Port `req`: input, 16 bits, request matrix; `req[4*i+j]` = input i requests output j (i,j in 0..3).
REQ-006 Port `tail`: input, 4 bits; `tail[i]` = input i is sending its last flit this cycle.
REQ-007 Port `grant`: output, 16 bits, registered grant matrix with the same indexing as `req`.
REQ-008 Port `grant_valid`: output, 1 bit, OR of all `grant` bits.
REQ-009 Port `ptr`: output, 4 bits, registered priority origin; row pr = `ptr[3:2]`, column pc = `ptr[1:0]`.

Function
REQ-010 The `grant` register SHALL hold at most one set bit per row and at most one per column at all times.
REQ-011 Lock evaluation at each edge, for each row i holding grant (i,j):
- Retain: if `req[4i+j]`=1 and `tail[i]`=0, the grant is retained, and row i and column j are unavailable for new allocation.
- Release: otherwise the grant is released, and row i and column j become available at this same edge.
REQ-012 Allocation when `en`=1:
- Free cells (available row, available column) are visited in wave order d = r'+c' for d = 0..6.
- r' = (r-pr) mod 4 and c' = (c-pc) mod 4.
- A cell is granted if its `req` bit is 1 and its row and column are both still free.
- A granted cell marks its row and column as taken for later waves.
REQ-013 Cells within one wave share no row or column, so visiting order within a wave SHALL NOT affect the result.
REQ-014 The next `grant` value SHALL be the retained grants OR the new grants, registered with 1-cycle latency from `req`.
REQ-015 Pointer update: if at least one new (non-retained) grant is issued at an edge, `ptr` SHALL increment by 1 mod 16 (15 wraps to 0); otherwise it holds.
REQ-016 When `en`=0:
- No new grants are issued.
- Lock evaluation per REQ-011 still applies, so held grants persist or release.
- `ptr` holds.
REQ-017 A released row or column SHALL be re-grantable at the same edge it is released, to the same or a different requester.
REQ-018 The block SHALL update all state only at the rising edge of `clk`; outputs SHALL have no combinational path from inputs.

Reset
REQ-019 When `rst`=1 at an edge, `grant` SHALL become 16'h0000, `grant_valid` 0 and `ptr` 4'h0, overriding `en`, `req` and `tail`.
REQ-020 Reset mid-packet SHALL drop all locks; no retained state survives reset.

Verification
REQ-021 Full load, rotation:
- After reset, `en`=1, `tail`=4'hF, `req`=16'hFFFF.
- First edge -> `grant`=16'h8421, `ptr`=1.
- Next edge -> `grant`=16'h1842, `ptr`=2.
REQ-022 Lock hold:
- After reset, `req`=16'h0001, `tail`=0 -> `grant`=16'h0001, `ptr`=1.
- Then `req`=16'h0013 -> `grant` stays 16'h0001, `ptr` stays 1.
REQ-023 Tail release and same-edge reallocation:
- Continue REQ-022 with `tail[0]`=1 and `req`=16'h0013.
- Result -> `grant`=16'h0012, `ptr`=2.
REQ-024 Request drop: with grant 16'h0001 held, set `req`=16'h0000 -> next edge `grant`=16'h0000, `grant_valid`=0, `ptr` unchanged.
REQ-025 Enable off: after reset, `en`=0, `req`=16'hFFFF for 4 cycles -> `grant`=16'h0000, `ptr`=0 throughout.
REQ-026 Reset mid-operation and pointer wrap:
- With locks held, assert `rst` for 1 cycle -> `grant`=16'h0000, `ptr`=0.
- Over 16 consecutive new-grant edges `ptr` SHALL go 0..15 and then back to 0.
- The REQ-010 invariant is checked every cycle.
